// File: rtl/load_store_unit_if.sv
// Memory-side bus between the load/store unit (master) and a memory or fabric port (slave).
// The master holds its request steady while valid is high. The slave completes the access by raising ready.
interface load_store_unit_if;
  logic        valid;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, we, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, we, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit with an IDLE -> BUSY -> RESP handshake toward the memory bus and a bus timeout.
// Optional macro MISALIGN_CHECK_EN rejects misaligned halfword and word accesses instead of aligning them.
module load_store_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [2:0]              funct3,
  input  logic [31:0]             ALUResult,
  input  logic [31:0]             WriteData,
  output logic [31:0]             ReadData,
  output logic                    Stall,
  output logic                    Error,
  output logic                    Misaligned,
  load_store_unit_if.master       bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;

  logic        req, req_byte, req_half, mis_req;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  assign req = MemRead | MemWrite;

  // A store decodes only SB/SH as sub-word; every other store funct3 is SW.
  // A load decodes funct3[1:0], so that BU and HU share their size with B and H.
  always_comb begin
    req_byte = MemWrite ? (funct3 == 3'b000) : (funct3[1:0] == 2'b00);
    req_half = MemWrite ? (funct3 == 3'b001) : (funct3[1:0] == 2'b01);
  end

`ifdef MISALIGN_CHECK_EN
  assign mis_req = (req_half & ALUResult[0]) | (!req_byte & !req_half & (ALUResult[1:0] != 2'b00));
`else
  assign mis_req = 1'b0;
`endif

  always_comb begin
    req_wstrb = 4'b0000;
    req_wdata = WriteData;
    if (MemWrite) begin
      if (req_byte) begin
        req_wstrb = 4'b0001 << ALUResult[1:0];
        req_wdata = {4{WriteData[7:0]}};
      end else if (req_half) begin
        req_wstrb = 4'b0011 << {ALUResult[1], 1'b0};
        req_wdata = {2{WriteData[15:0]}};
      end else begin
        req_wstrb = 4'b1111;
      end
    end
  end

  // Select the load lane from the returned word. Bit 2 of funct3 selects zero extension.
  always_comb begin
    ld_byte = bus.rdata[8*addr_q[1:0] +: 8];
    ld_half = addr_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
    if (funct3_q[1:0] == 2'b00) begin
      ld_fmt = {{24{ld_byte[7] & !funct3_q[2]}}, ld_byte};
    end else if (funct3_q[1:0] == 2'b01) begin
      ld_fmt = {{16{ld_half[15] & !funct3_q[2]}}, ld_half};
    end else begin
      ld_fmt = bus.rdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    mis_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d   = ALUResult;
          wdata_d  = req_wdata;
          wstrb_d  = req_wstrb;
          funct3_d = funct3;
          we_d     = MemWrite;
          cnt_d    = 4'd0;
          if (mis_req) begin
            state_d = RESP;
            mis_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.ready) begin
          state_d = RESP;
          if (!we_q) rdata_d = ld_fmt;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == TIMEOUT_CNT) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
      cnt_q    <= 4'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      mis_q    <= mis_d;
    end
  end

  // bus_valid decodes straight from state, so an asynchronous reset withdraws the request at once.
  assign bus.valid = (state_q == BUSY);
  assign bus.we    = we_q;
  assign bus.addr  = {addr_q[31:2], 2'b00};
  assign bus.wdata = wdata_q;
  assign bus.wstrb = wstrb_q;

  assign Stall    = ((state_q == IDLE) & req) | (state_q == BUSY);
  assign ReadData = rdata_q;
  assign Error    = err_q;
`ifdef MISALIGN_CHECK_EN
  assign Misaligned = mis_q;
`else
  assign Misaligned = 1'b0 & mis_q;
`endif

endmodule
